// File: rtl/tmr_cap_filt_pkg.sv
// Shared types and defaults for the timer capture input conditioning stage.
// Edge-select encoding and the edge qualification helper live here.
package tmr_cap_filt_pkg;

    localparam int TMR_CAP_SDIV_WIDTH = 8;
    localparam int TMR_CAP_FILT_WIDTH = 4;
    localparam int TMR_CAP_PSC_WIDTH  = 3;

    typedef enum logic [1:0] {
        TMR_CAP_EDGE_RISE = 2'b00,
        TMR_CAP_EDGE_FALL = 2'b01,
        TMR_CAP_EDGE_BOTH = 2'b10,
        TMR_CAP_EDGE_NONE = 2'b11
    } cap_edge_e;

    // lvl is the new filtered level after the edge event
    function automatic logic edge_match(input logic [1:0] sel,
                                        input logic       lvl);
        logic m;
        m = 1'b0;
        unique case (cap_edge_e'(sel))
            TMR_CAP_EDGE_RISE: m = lvl;
            TMR_CAP_EDGE_FALL: m = ~lvl;
            TMR_CAP_EDGE_BOTH: m = 1'b1;
            TMR_CAP_EDGE_NONE: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmr_cap_smp_div.sv
// Sample-tick divider for the capture filter.
// Ticks once every sdiv_i+1 enabled cycles; held at zero while disabled.
module tmr_cap_smp_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] sdiv_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] sdiv_cnt;

    // >= so a lowered period ticks at once instead of wrapping
    assign tick_o = en_i && (sdiv_cnt >= sdiv_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sdiv_cnt <= '0;
        end else if (!en_i || tick_o) begin
            sdiv_cnt <= '0;
        end else begin
            sdiv_cnt <= sdiv_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tmr_cap_filt.sv
// Capture pin conditioning: synchroniser, sampled-run glitch filter,
// edge select and edge prescaler feeding the timer capture channel.
module tmr_cap_filt
    import tmr_cap_filt_pkg::*;
#(
    parameter int SDIV_WIDTH = TMR_CAP_SDIV_WIDTH,
    parameter int FILT_WIDTH = TMR_CAP_FILT_WIDTH,
    parameter int PSC_WIDTH  = TMR_CAP_PSC_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [SDIV_WIDTH-1:0] sdiv_i,
    input  logic [FILT_WIDTH-1:0] flen_i,
    input  logic [1:0]            esel_i,
    input  logic [PSC_WIDTH-1:0]  psc_i,
    input  logic                  cap_i,
    output logic                  cap_o,
    output logic                  cap_pls_o,
    output logic                  glitch_o
);

    logic                  s_meta;
    logic                  s_smp;
    logic                  tick;
    logic [FILT_WIDTH-1:0] run_cnt;
    logic [FILT_WIDTH-1:0] run_nxt;
    logic [PSC_WIDTH-1:0]  psc_cnt;
    logic [PSC_WIDTH-1:0]  psc_nxt;
    logic                  cap_nxt;
    logic                  glitch_nxt;
    logic                  pls_nxt;
    logic                  edge_evt;
    logic                  edge_qual;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_meta <= 1'b0;
            s_smp  <= 1'b0;
        end else begin
            s_meta <= cap_i;
            s_smp  <= s_meta;
        end
    end

    tmr_cap_smp_div #(
        .WIDTH (SDIV_WIDTH)
    ) u_smp_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .sdiv_i (sdiv_i),
        .tick_o (tick)
    );

    always_comb begin
        cap_nxt    = cap_o;
        run_nxt    = run_cnt;
        glitch_nxt = 1'b0;
        edge_evt   = 1'b0;
        if (!en_i) begin
            cap_nxt = s_smp;
            run_nxt = '0;
        end else if (tick) begin
            if (s_smp == cap_o) begin
                run_nxt    = '0;
                glitch_nxt = (run_cnt != '0);
            end else if (run_cnt >= flen_i) begin
                cap_nxt  = s_smp;
                run_nxt  = '0;
                edge_evt = 1'b1;
            end else begin
                run_nxt = run_cnt + 1'b1;
            end
        end
    end

    assign edge_qual = edge_evt && edge_match(esel_i, s_smp);

    always_comb begin
        psc_nxt = psc_cnt;
        pls_nxt = 1'b0;
        if (!en_i) begin
            psc_nxt = '0;
        end else if (edge_qual) begin
            if (psc_cnt >= psc_i) begin
                pls_nxt = 1'b1;
                psc_nxt = '0;
            end else begin
                psc_nxt = psc_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_o     <= 1'b0;
            cap_pls_o <= 1'b0;
            glitch_o  <= 1'b0;
            run_cnt   <= '0;
            psc_cnt   <= '0;
        end else begin
            cap_o     <= cap_nxt;
            cap_pls_o <= pls_nxt;
            glitch_o  <= glitch_nxt;
            run_cnt   <= run_nxt;
            psc_cnt   <= psc_nxt;
        end
    end

endmodule

// File: tb/tb_tmr_cap_filt.sv
// Bench for tmr_cap_filt: directed table, reset corner case and
// randomized traffic against a sample-list reference model.
module tb_tmr_cap_filt;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] sdiv;
    logic [3:0] flen;
    logic [1:0] esel;
    logic [2:0] psc;
    logic       cap;
    logic       cap_o;
    logic       cap_pls;
    logic       glitch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tmr_cap_filt dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .sdiv_i    (sdiv),
        .flen_i    (flen),
        .esel_i    (esel),
        .psc_i     (psc),
        .cap_i     (cap),
        .cap_o     (cap_o),
        .cap_pls_o (cap_pls),
        .glitch_o  (glitch)
    );

    // reference model: pin delay line, list of pending differing samples,
    // enabled-cycle count for ticks, qualified-edge count for prescaling
    bit m_meta, m_smp, m_cap, m_pls, m_gl;
    bit pend[$];
    int cyc_en;
    int qcnt;

    task automatic model_reset();
        m_meta = 0; m_smp = 0; m_cap = 0; m_pls = 0; m_gl = 0;
        pend.delete();
        cyc_en = 0;
        qcnt = 0;
    endtask

    function automatic bit wanted(bit lvl);
        case (esel)
            2'd0: return lvl;
            2'd1: return !lvl;
            2'd2: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit seen;
        seen = m_smp;
        m_smp = m_meta;
        m_meta = cap;
        m_pls = 0;
        m_gl = 0;
        if (!en) begin
            m_cap = seen;
            pend.delete();
            cyc_en = 0;
            qcnt = 0;
        end else begin
            cyc_en++;
            if (cyc_en % (int'(sdiv) + 1) == 0) begin
                if (seen == m_cap) begin
                    m_gl = (pend.size() > 0);
                    pend.delete();
                end else begin
                    pend.push_back(seen);
                    if (pend.size() > int'(flen)) begin
                        m_cap = seen;
                        pend.delete();
                        if (wanted(seen)) begin
                            qcnt++;
                            m_pls = (qcnt % (int'(psc) + 1) == 0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".cap_o"}, cap_o, m_cap);
        chk({tag, ".cap_pls_o"}, cap_pls, m_pls);
        chk({tag, ".glitch_o"}, glitch, m_gl);
    endtask

    typedef struct {
        logic en;
        logic cap;
        logic e_cap;
        logic e_pls;
        logic e_gl;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // clean rise at flen=3 then a 3-cycle low glitch
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; cap = 1'b0;
        sdiv = 8'd0; flen = 4'd3; esel = 2'd0; psc = 3'd0;
        model_reset();
        #1;
        chk("reset.cap_o", cap_o, 1'b0);
        chk("reset.cap_pls_o", cap_pls, 1'b0);
        chk("reset.glitch_o", glitch, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            en  = tbl[i].en;
            cap = tbl[i].cap;
            step();
            chk($sformatf("tbl%0d.cap_o", i), cap_o, tbl[i].e_cap);
            chk($sformatf("tbl%0d.cap_pls_o", i), cap_pls, tbl[i].e_pls);
            chk($sformatf("tbl%0d.glitch_o", i), glitch, tbl[i].e_gl);
            chk_model($sformatf("tblm%0d", i));
        end

        // randomized segments; config only changes while disabled
        for (int s = 0; s < 60; s++) begin
            int len;
            int hold;
            en = ($urandom_range(0, 3) != 0);
            if (!en) begin
                sdiv = 8'($urandom_range(0, 3));
                flen = 4'($urandom_range(0, 5));
                esel = 2'($urandom_range(0, 3));
                psc  = 3'($urandom_range(0, 3));
            end
            len = $urandom_range(20, 60);
            hold = 0;
            for (int c = 0; c < len; c++) begin
                if (hold == 0) begin
                    cap = ~cap;
                    hold = $urandom_range(1, 14);
                end
                hold--;
                step();
                chk_model($sformatf("rnd%0d_%0d", s, c));
            end
        end

        // reset mid-run: cap_o high, filter part way into a fall
        en = 1'b0; cap = 1'b1;
        sdiv = 8'd0; flen = 4'd3; esel = 2'd2; psc = 3'd1;
        for (int c = 0; c < 4; c++) step();
        en = 1'b1;
        for (int c = 0; c < 5; c++) step();
        cap = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk_model("pre_rst");
        chk("pre_rst.level", cap_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.cap_o", cap_o, 1'b0);
        chk("async_rst.cap_pls_o", cap_pls, 1'b0);
        chk("async_rst.glitch_o", glitch, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cap = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk_model($sformatf("post_rst%0d", c));
            if (c == 5) chk("post_rst.early", cap_o, 1'b0);
            if (c == 6) chk("post_rst.rise", cap_o, 1'b1);
            if (c == 6) chk("post_rst.psc", cap_pls, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
